// File: rtl/btn_event_arbiter_if.sv
// Event stream handshake between btn_event_arbiter and its consumer.
//   ev_valid : FIFO head holds an event (source -> sink)
//   ev_id    : channel index of the head event, 0 when empty (source -> sink)
//   ev_ready : sink accepts the head this cycle (sink -> source)
interface btn_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           ev_valid;
  logic           ev_ready;
  logic [IDW-1:0] ev_id;

  modport master (output ev_valid, output ev_id, input ev_ready);
  modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: turns per-button press pulses into one ordered stream of
// button-ID events. Each channel edge-detects and holds off its pulse, keeps
// a pending flag, and a round-robin arbiter pushes one pending channel per
// cycle into a small FWFT FIFO that the consumer drains with valid/ready.
//   clk, rstn   : clock, async active-low reset
//   pulse       : debounced press pulses, one bit per button
//   ev          : event stream (master side of btn_event_arbiter_if)
//   pending     : per-channel press latched, not yet granted
//   ev_overflow : sticky lost-press flag, cleared by clr_ovf (set wins)

// Per-channel front end: edge detect, holdoff counter, pending flag.
module btn_event_chan #(
  parameter int HOLDOFF = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic pulse_i,
  input  logic grant_i,
  output logic pending_o,
  output logic lost_o
);
  logic       pulse_d_q;
  logic [7:0] hold_q, hold_d;
  logic       pend_q, pend_d;
  logic       acc;

  // pulse_d resets to 0, so a pulse already high at release reads as a rise.
  assign acc = pulse_i & ~pulse_d_q & (hold_q == 8'd0);

  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    if (acc)                 hold_d = 8'(HOLDOFF);
    else if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
    // A new press always wins over a same-cycle grant, so pending stays set.
    if (acc)          pend_d = 1'b1;
    else if (grant_i) pend_d = 1'b0;
  end

  assign lost_o    = acc & pend_q & ~grant_i;
  assign pending_o = pend_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_d_q <= 1'b0;
      hold_q    <= 8'd0;
      pend_q    <= 1'b0;
    end else begin
      pulse_d_q <= pulse_i;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
    end
  end
endmodule

module btn_event_arbiter #(
  parameter int N       = 4,
  parameter int HOLDOFF = 8,
  parameter int DEPTH   = 4,
  parameter int IDW     = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         pulse,
  btn_event_arbiter_if.master  ev,
  output logic [N-1:0]         pending,
  output logic                 ev_overflow,
  input  logic                 clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]   grant, lost;
  logic [IDW-1:0] rr_last_q, rr_last_d;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found, gnt_en;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           push, pop;
  logic [IDW-1:0] mem_q [DEPTH];

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign grant[g] = gnt_en & (gnt_idx == IDW'(g));
    btn_event_chan #(.HOLDOFF(HOLDOFF)) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .pulse_i   (pulse[g]),
      .grant_i   (grant[g]),
      .pending_o (pending[g]),
      .lost_o    (lost[g])
    );
  end

  // Round robin: first pending above rr_last, else first pending at or below.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_found && pending[i] && (i > int'(rr_last_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_found && pending[i] && (i <= int'(rr_last_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
  end

  // Registered count only: a pop this cycle does not free a slot until next.
  assign gnt_en = gnt_found & (count_q < CW'(DEPTH));
  assign push   = gnt_en;
  assign pop    = (count_q != '0) & ev.ev_ready;

  always_comb begin
    rr_last_d = gnt_en ? gnt_idx : rr_last_q;
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    ovf_d     = ovf_q;
    if (|lost)        ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last_q <= IDW'(N - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the head is gated to 0 whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_id    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign ev_overflow = ovf_q;
endmodule
